param_coeff_loader: RTL

PARAM_COEFF_LOADER -- requirements
Module: param_coeff_loader

---
 rtl/coeff_loader_pkg.sv | 24 ++
 rtl/coeff_index_counter.sv | 35 +++
 rtl/param_coeff_loader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/coeff_loader_pkg.sv
// -----------------------------------------------------------------------------
// coeff_loader_pkg
// Shared types and constants for the coefficient loader.
//   loader_state_t : 2-bit FSM state encoding (IDLE, LOAD, WAIT, DONE)
//   MIN_COEFFS / MAX_COEFFS : supported range for the set size
//   last_index()   : index of the final coefficient in a set of n
// -----------------------------------------------------------------------------
package coeff_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } loader_state_t;

  localparam int unsigned MIN_COEFFS = 2;
  localparam int unsigned MAX_COEFFS = 16;

  function automatic int unsigned last_index(input int unsigned n);
    return n - 1;
  endfunction

endpackage

// File: rtl/coeff_index_counter.sv
// -----------------------------------------------------------------------------
// coeff_index_counter
// Up-counter holding the coefficient index of the loader.
//   clk, n_reset   : clock, async active-low reset (count -> 0)
//   clear          : synchronous return to 0 (has priority over counting)
//   count_enable   : advance by one on the next rising edge
//   rollover_value : last legal value; counting past it returns to 0
//   count          : current index
// -----------------------------------------------------------------------------
module coeff_index_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_value,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      if (count == rollover_value) begin
        count <= '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/param_coeff_loader.sv
// -----------------------------------------------------------------------------
// param_coeff_loader
// Sequences the loading of NUM_COEFFS coefficients into a datapath, one
// strobe per coefficient, pacing each step on the downstream busy flag.
//   clk, n_reset        : clock, async active-low reset
//   new_coefficient_set : request to load a full set
//   modwait             : downstream busy; holds off the next strobe
//   abort               : cancel the set in progress and any pending request
//   load_coeff          : one-cycle capture strobe
//   coefficient_num     : index being / last loaded
//   busy                : FSM not idle
//   load_done           : one-cycle pulse after the final coefficient
//   pending             : a request is latched and waiting
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no set in progress; waiting for a request and !modwait
// LOAD   | strobe load_coeff for the current index
// WAIT   | between strobes; advance index once modwait is low
// DONE   | final coefficient loaded; pulse load_done, return to IDLE
// -----------------------------------------------------------------------------
module param_coeff_loader
  import coeff_loader_pkg::*;
#(
  parameter  int unsigned NUM_COEFFS = 4,
  localparam int unsigned IDX_W      = $clog2(NUM_COEFFS)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             new_coefficient_set,
  input  logic             modwait,
  input  logic             abort,
  output logic             load_coeff,
  output logic [IDX_W-1:0] coefficient_num,
  output logic             busy,
  output logic             load_done,
  output logic             pending
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(last_index(NUM_COEFFS));

  loader_state_t    state;
  loader_state_t    state_next;
  logic             idx_clear;
  logic             idx_step;
  logic             pending_next;
  logic [IDX_W-1:0] index;

  coeff_index_counter #(
    .WIDTH (IDX_W)
  ) u_index (
    .clk            (clk),
    .n_reset        (n_reset),
    .clear          (idx_clear),
    .count_enable   (idx_step),
    .rollover_value (LAST_IDX),
    .count          (index)
  );

  // Index only ever moves on a set start, a WAIT->LOAD step or abort,
  // so it holds its last value through DONE and IDLE.
  always_comb begin
    state_next = state;
    idx_clear  = 1'b0;
    idx_step   = 1'b0;
    if (abort) begin
      state_next = S_IDLE;
      idx_clear  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if ((new_coefficient_set | pending) & ~modwait) begin
            state_next = S_LOAD;
            idx_clear  = 1'b1;
          end
        end
        S_LOAD: begin
          state_next = (index == LAST_IDX) ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (!modwait) begin
            state_next = S_LOAD;
            idx_step   = 1'b1;
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // A request is consumed only by the IDLE->LOAD transition; anything else
  // latches it, and repeated requests collapse into the single flag.
  always_comb begin
    pending_next = pending;
    if (abort) begin
      pending_next = 1'b0;
    end else if ((state == S_IDLE) && (state_next == S_LOAD)) begin
      pending_next = 1'b0;
    end else if (new_coefficient_set) begin
      pending_next = 1'b1;
    end
  end

  // Outputs are registered from the next state, so each one is a pure
  // decode of the current state while staying glitch-free.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= S_IDLE;
      pending    <= 1'b0;
      load_coeff <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      state      <= state_next;
      pending    <= pending_next;
      load_coeff <= (state_next == S_LOAD);
      busy       <= (state_next != S_IDLE);
      load_done  <= (state_next == S_DONE);
    end
  end

  assign coefficient_num = index;

  a_index_in_range : assert property (
    @(posedge clk) disable iff (!n_reset) (index <= LAST_IDX)
  );

endmodule
